// File: rtl/mic_pkg.sv
// Shared constants and output FSM encoding for the multi-channel I2S mic capture engine.
package mic_pkg;

    localparam int MIC_CLK_DIV   = 10;
    localparam int MIC_SLOT_BITS = 32;
    localparam int MIC_DATA_W    = 24;
    localparam int MIC_OUT_W     = 16;
    localparam int MIC_NUM_CH    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } mic_state_e;

endpackage

// File: rtl/i2s_rx_lane.sv
// One I2S data lane: 2-flop synchroniser, DATA_W MSB-first shifter and OUT_W word formatting.
// MIC_CAPTURE_ROUND_EN selects round-half-up with positive saturation instead of truncation.
module i2s_rx_lane
    import mic_pkg::*;
#(
    parameter int DATA_W = MIC_DATA_W,
    parameter int OUT_W  = MIC_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_i,
    input  logic             rise_stb,
    input  logic             window,
    output logic [OUT_W-1:0] word_o
);

    logic [1:0]        sync_q, sync_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [OUT_W-1:0]  top_bits;

    always_comb begin
        sync_d  = {sync_q[0], data_i};
        shift_d = shift_q;
        if (rise_stb && window) begin
            shift_d = {shift_q[DATA_W-2:0], sync_q[1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= sync_d;
            shift_q <= shift_d;
        end
    end

    assign top_bits = shift_q[DATA_W-1 -: OUT_W];

`ifdef MIC_CAPTURE_ROUND_EN
    localparam int RB = (DATA_W > OUT_W) ? DATA_W - OUT_W - 1 : 0;
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    logic round_bit;
    assign round_bit = (DATA_W > OUT_W) ? shift_q[RB] : 1'b0;
`endif

    always_comb begin
        word_o = top_bits;
`ifdef MIC_CAPTURE_ROUND_EN
        // Only +max can overflow when adding one half-LSB; it clamps in place.
        if (round_bit && (top_bits != MAX_POS)) begin
            word_o = top_bits + OUT_W'(1);
        end
`endif
    end

endmodule

// File: rtl/mic_array_capture.sv
// Multi-lane I2S mic capture: SCK/WS generation by clock-enable, per-lane deserialisers,
// frame holding register streamed out channel by channel, dropped-frame accounting.
// Optional MIC_CAPTURE_ROUND_EN rounds samples inside each lane.
module mic_array_capture
    import mic_pkg::*;
#(
    parameter int CLK_DIV   = MIC_CLK_DIV,
    parameter int SLOT_BITS = MIC_SLOT_BITS,
    parameter int DATA_W    = MIC_DATA_W,
    parameter int OUT_W     = MIC_OUT_W,
    parameter int NUM_CH    = MIC_NUM_CH,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              capture_en,
    input  logic [NUM_CH-1:0] mic_data_i,
    output logic              mic_sck_o,
    output logic              mic_ws_o,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic [CH_W-1:0]   m_chan,
    output logic              m_last,
    output logic              ovf_sticky,
    output logic [15:0]       ovf_count
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] BIT_DONE = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [CH_W-1:0]  IDX_LAST = CH_W'(NUM_CH - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    mic_state_e       state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [15:0]      ovf_count_q, ovf_count_d;
    logic [NUM_CH-1:0][OUT_W-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0][OUT_W-1:0] lane_words;

    logic rise_stb, fall_stb, window;

    assign rise_stb = (div_cnt_q == DIV_RISE);
    assign fall_stb = (div_cnt_q == DIV_LAST);
    // One-bit I2S delay: the MSB sits in slot bit 1.
    assign window   = (bit_cnt_q != '0) && (bit_cnt_q <= BIT_DONE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        i2s_rx_lane #(
            .DATA_W (DATA_W),
            .OUT_W  (OUT_W)
        ) u_lane (
            .clk      (sys_clk),
            .rst_n    (sys_rst_n),
            .data_i   (mic_data_i[g]),
            .rise_stb (rise_stb),
            .window   (window),
            .word_o   (lane_words[g])
        );
    end

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        sck_d     = (div_cnt_d >= DIV_HALF);
        bit_cnt_d = bit_cnt_q;
        if (fall_stb) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
        ws_d    = (bit_cnt_d >= BIT_SLOT);
        armed_d = armed_q;
        if (rise_stb && (bit_cnt_q == '0)) begin
            armed_d = capture_en;
        end
        // The last shift and this flag land on the same edge, so the load sees a full word.
        done_d = rise_stb && (bit_cnt_q == BIT_DONE) && armed_q;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        ovf_sticky_d = ovf_sticky_q;
        ovf_count_d  = ovf_count_q;
        m_valid      = 1'b0;
        m_data       = '0;
        m_chan       = '0;
        m_last       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (done_q) begin
                    hold_d  = lane_words;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                m_valid = 1'b1;
                m_data  = hold_q[idx_q];
                m_chan  = idx_q;
                m_last  = (idx_q == IDX_LAST);
                if (m_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (done_q) begin
                    ovf_sticky_d = 1'b1;
                    if (ovf_count_q != 16'hFFFF) begin
                        ovf_count_d = ovf_count_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            hold_q       <= '0;
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign mic_sck_o  = sck_q;
    assign mic_ws_o   = ws_q;
    assign ovf_sticky = ovf_sticky_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_mic_array_capture.sv
// Bench for mic_array_capture: a mic model drives the lanes from SCK/WS, each armed frame
// pushes its expected beats into exp_q, and a monitor pops/compares on every output beat.
module tb_mic_array_capture;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 24;
    localparam int OUT_W  = 16;
    localparam int CH_W   = 2;
    localparam int EW     = OUT_W + CH_W + 1;
`ifdef MIC_CAPTURE_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              capture_en;
    logic [NUM_CH-1:0] mic_data_i = '0;
    logic              mic_sck_o, mic_ws_o, m_valid, m_ready, m_last, ovf_sticky;
    logic [OUT_W-1:0]  m_data;
    logic [CH_W-1:0]   m_chan;
    logic [15:0]       ovf_count;

    always #5 sys_clk = ~sys_clk;

    mic_array_capture dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .capture_en (capture_en),
        .mic_data_i (mic_data_i),
        .mic_sck_o  (mic_sck_o),
        .mic_ws_o   (mic_ws_o),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_chan     (m_chan),
        .m_last     (m_last),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    e;
    logic [DATA_W-1:0] lane_sample[NUM_CH];
    logic [DATA_W-1:0] cur_sample[NUM_CH];
    logic [OUT_W-1:0]  lane_expect[NUM_CH];
    int   k = 0;
    int   skip_cnt = 0;
    int   hs_count = 0;
    int   hs_before;
    int   cyc = 0;
    int   stb_cyc = 0;
    logic lat_arm = 1'b0;
    logic sck_prev = 1'b0;
    logic valid_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_set(input int s);
        if (s == 0) begin
            lane_sample[0] = 24'h123456; lane_expect[0] = 16'h1234;
            lane_sample[1] = 24'hFEDCBA; lane_expect[1] = ROUND ? 16'hFEDD : 16'hFEDC;
            lane_sample[2] = 24'h000100; lane_expect[2] = 16'h0001;
            lane_sample[3] = 24'h800000; lane_expect[3] = 16'h8000;
        end else begin
            lane_sample[0] = 24'h123480; lane_expect[0] = ROUND ? 16'h1235 : 16'h1234;
            lane_sample[1] = 24'h7FFF80; lane_expect[1] = 16'h7FFF;
            lane_sample[2] = 24'h7FFFFF; lane_expect[2] = 16'h7FFF;
            lane_sample[3] = 24'hFFFF80; lane_expect[3] = ROUND ? 16'h0000 : 16'hFFFF;
        end
    endtask

    // ---------------- mic model ----------------
    // k follows the slot bit position; data changes on SCK fall, MSB in slot bit 1.
    always @(negedge mic_sck_o or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            k = 0;
            mic_data_i = '0;
        end else begin
            k = (k + 1) % 64;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mic_data_i[ch] = (k >= 1 && k <= DATA_W) ? cur_sample[ch][DATA_W-k] : 1'b0;
            end
        end
    end

    // Frame gate: the frame is armed if capture_en is high at the bit-0 SCK rise.
    always @(posedge mic_sck_o) begin
        if (sys_rst_n && k == 0) begin
            for (int ch = 0; ch < NUM_CH; ch++) cur_sample[ch] = lane_sample[ch];
            if (capture_en) begin
                if (skip_cnt > 0) begin
                    skip_cnt--;
                end else begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        exp_q.push_back({lane_expect[ch], CH_W'(ch), 1'(ch == NUM_CH - 1)});
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst_n) begin
            if (!sck_prev && mic_sck_o && k == DATA_W) stb_cyc = cyc - 1;
            if (lat_arm && m_valid && !valid_prev) begin
                check("first_valid_latency", cyc - stb_cyc, 2);
                lat_arm = 1'b0;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got chan %0d data %0h, expected no output (t=%0t)",
                             m_chan, m_data, $time);
                end else begin
                    e = exp_q[0];
                    check("m_data", 32'(m_data), 32'(e[EW-1 -: OUT_W]));
                    check("m_chan", 32'(m_chan), 32'(e[CH_W:1]));
                    check("m_last", 32'(m_last), 32'(e[0]));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
            end
        end
        sck_prev   = mic_sck_o;
        valid_prev = m_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_k(input int target);
        int n = 0;
        while (k == target && n < 2000) begin @(negedge sys_clk); n++; end
        while (k != target && n < 2000) begin @(negedge sys_clk); n++; end
        n_checks++;
        if (n >= 2000) begin
            n_errors++;
            $display("FAIL wait_k: got timeout waiting for bit %0d, required bit reached", target);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin @(negedge sys_clk); n++; end
        n_checks++;
        if (n >= 4000) begin
            n_errors++;
            $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_m_valid"},    32'(m_valid),    0);
        check({tag, "_m_data"},     32'(m_data),     0);
        check({tag, "_m_chan"},     32'(m_chan),     0);
        check({tag, "_m_last"},     32'(m_last),     0);
        check({tag, "_mic_sck_o"},  32'(mic_sck_o),  0);
        check({tag, "_mic_ws_o"},   32'(mic_ws_o),   0);
        check({tag, "_ovf_sticky"}, 32'(ovf_sticky), 0);
        check({tag, "_ovf_count"},  32'(ovf_count),  0);
    endtask

    task automatic measure_pins();
        int   hi = 0, lo = 0, wsn = 0, n = 0;
        logic w0;
        while (mic_sck_o !== 1'b0 && n < 50) begin @(negedge sys_clk); n++; end
        while (mic_sck_o !== 1'b1 && n < 50) begin @(negedge sys_clk); n++; end
        while (mic_sck_o === 1'b1 && hi < 50) begin hi++; @(negedge sys_clk); end
        while (mic_sck_o === 1'b0 && lo < 50) begin lo++; @(negedge sys_clk); end
        check("sck_high_cycles", hi, 5);
        check("sck_low_cycles", lo, 5);
        check("sck_period", hi + lo, 10);
        w0 = mic_ws_o;
        n  = 0;
        while (mic_ws_o === w0 && n < 1000) begin @(negedge sys_clk); n++; end
        w0 = mic_ws_o;
        while (mic_ws_o === w0 && wsn < 1000) begin wsn++; @(negedge sys_clk); end
        check("ws_half_period", wsn, 320);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3ms;
        $display("FAIL watchdog: got no completion by 3 ms, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        sys_rst_n  = 1'b0;
        capture_en = 1'b0;
        m_ready    = 1'b1;
        load_set(0);
        for (int ch = 0; ch < NUM_CH; ch++) cur_sample[ch] = '0;
        repeat (4) @(negedge sys_clk);
        reset_outputs_zero("reset");
        sys_rst_n = 1'b1;

        measure_pins();

        // Streaming, two vector sets, first-valid latency
        wait_k(32);
        load_set(0);
        capture_en = 1'b1;
        lat_arm    = 1'b1;
        wait_k(0);
        wait_k(32);
        load_set(1);
        wait_k(0);
        wait_k(32);
        load_set(0);
        wait_drain();
        check("latency_observed", 32'(lat_arm), 0);

        // Backpressure: first frame held stable, next two frames dropped
        m_ready = 1'b0;
        wait_k(0);
        wait_k(32);
        skip_cnt = 2;
        check("ovf_count_before_stall", 32'(ovf_count), 0);
        repeat (1500) @(negedge sys_clk);
        m_ready = 1'b1;
        wait_drain();
        repeat (2) @(negedge sys_clk);
        check("ovf_count_after_stall", 32'(ovf_count), 2);
        check("ovf_sticky_after_stall", 32'(ovf_sticky), 1);

        // Frame gate: enable raised mid-frame takes effect from the next frame
        wait_k(32);
        wait_drain();
        capture_en = 1'b0;
        wait_k(10);
        capture_en = 1'b1;
        hs_before  = hs_count;
        wait_k(0);
        check("gate_no_early_output", hs_count, hs_before);
        wait_k(32);
        check("gate_frame_delivered", hs_count, hs_before + 4);

        // Reset during beat 2
        wait_k(20);
        begin
            int n = 0;
            while (!(m_valid === 1'b1 && m_chan === 2'd2) && n < 400) begin @(negedge sys_clk); n++; end
            check("beat2_reached", 32'(m_chan), 2);
        end
        sys_rst_n = 1'b0;
        #1;
        reset_outputs_zero("midreset");
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        hs_before = hs_count;
        wait_k(32);
        check("post_reset_frame_beats", hs_count, hs_before + 4);
        wait_drain();
        check("post_reset_ovf_count", 32'(ovf_count), 0);

        repeat (5) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
